// File: rtl/glb_router_sched.sv
// Transfer scheduler between the GLB and router clusters: arbitrates iact/wght
// loads and psum writebacks, then sequences GLB addresses and router strobes.
module glb_router_sched #(
    parameter int ADDR_BITWIDTH = 10,
    parameter int LEN_W         = 10
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     iact_req,
    input  logic                     wght_req,
    input  logic                     psum_req,
    input  logic [ADDR_BITWIDTH-1:0] iact_base,
    input  logic [ADDR_BITWIDTH-1:0] wght_base,
    input  logic [ADDR_BITWIDTH-1:0] psum_base,
    input  logic [LEN_W-1:0]         iact_len,
    input  logic [LEN_W-1:0]         wght_len,
    input  logic [LEN_W-1:0]         psum_len,
    input  logic [3:0]               iact_mode,
    input  logic [3:0]               wght_mode,
    input  logic [3:0]               psum_mode,
    output logic                     iact_grant,
    output logic                     wght_grant,
    output logic                     psum_grant,
    output logic                     iact_done,
    output logic                     wght_done,
    output logic                     psum_done,
    output logic                     read_req_iact,
    output logic                     read_req_wght,
    output logic [ADDR_BITWIDTH-1:0] r_addr_iact,
    output logic [ADDR_BITWIDTH-1:0] r_addr_wght,
    output logic                     west_enable_i_iact,
    output logic                     west_enable_i_wght,
    output logic [3:0]               router_mode_iact,
    output logic [3:0]               router_mode_wght,
    output logic [3:0]               router_mode_psum,
    input  logic                     west_enable_o_psum,
    output logic [ADDR_BITWIDTH-1:0] w_addr_psum,
    output logic                     busy
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD    = 3'd1,
        ST_DRAIN = 3'd2,
        ST_WB    = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [1:0]               CLS_IACT = 2'd0;
    localparam logic [1:0]               CLS_WGHT = 2'd1;
    localparam logic [1:0]               CLS_PSUM = 2'd2;
    localparam logic [LEN_W-1:0]         CNT_ONE  = LEN_W'(1'b1);
    localparam logic [ADDR_BITWIDTH-1:0] ADDR_ONE = ADDR_BITWIDTH'(1'b1);

    state_t                   state_r, state_s;
    logic [1:0]               cls_r, sel_cls_s;
    logic [ADDR_BITWIDTH-1:0] base_r, sel_base_s, addr_s;
    logic [LEN_W-1:0]         len_r, sel_len_s, cnt_r;
    logic [3:0]               mode_r, sel_mode_s;
    logic [2:0]               grant_s, done_s;
    logic                     rd_iact_s, rd_wght_s, strobe_s, last_s;

    assign last_s = (cnt_r == (len_r - CNT_ONE));

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_r <= ST_IDLE;
        else        state_r <= state_s;
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (psum_req)                  state_s = ST_WB;
                else if (iact_req || wght_req) state_s = ST_RD;
                else                           state_s = ST_IDLE;
            end
            ST_RD: begin
                if (last_s) state_s = ST_DRAIN;
                else        state_s = ST_RD;
            end
            ST_DRAIN: state_s = ST_DONE;
            ST_WB: begin
                if (west_enable_o_psum && last_s) state_s = ST_DONE;
                else                              state_s = ST_WB;
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Output decode: fixed-priority selection and per-cycle strobes
    always_comb begin
        grant_s    = 3'b000;
        sel_cls_s  = CLS_WGHT;
        sel_base_s = wght_base;
        sel_len_s  = wght_len;
        sel_mode_s = wght_mode;
        if (psum_req) begin
            sel_cls_s  = CLS_PSUM;
            sel_base_s = psum_base;
            sel_len_s  = psum_len;
            sel_mode_s = psum_mode;
        end else if (iact_req) begin
            sel_cls_s  = CLS_IACT;
            sel_base_s = iact_base;
            sel_len_s  = iact_len;
            sel_mode_s = iact_mode;
        end else begin
            sel_cls_s  = CLS_WGHT;
        end
        if (state_r == ST_IDLE) begin
            if (psum_req)      grant_s = 3'b100;
            else if (iact_req) grant_s = 3'b001;
            else if (wght_req) grant_s = 3'b010;
            else               grant_s = 3'b000;
        end else begin
            grant_s = 3'b000;
        end
        rd_iact_s = (state_r == ST_RD) && (cls_r == CLS_IACT);
        rd_wght_s = (state_r == ST_RD) && (cls_r == CLS_WGHT);
        strobe_s  = (state_r == ST_WB) && west_enable_o_psum;
        addr_s    = base_r + ADDR_BITWIDTH'(cnt_r);
        // psum completes on its last strobe; loads complete in DONE after the drain
        done_s[0] = (state_r == ST_DONE) && (cls_r == CLS_IACT);
        done_s[1] = (state_r == ST_DONE) && (cls_r == CLS_WGHT);
        done_s[2] = strobe_s && last_s;
    end

    // Descriptor capture and word counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cls_r  <= CLS_IACT;
            base_r <= '0;
            len_r  <= '0;
            mode_r <= 4'd0;
            cnt_r  <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (grant_s != 3'b000) begin
                        cls_r  <= sel_cls_s;
                        base_r <= sel_base_s;
                        len_r  <= (sel_len_s == '0) ? CNT_ONE : sel_len_s;
                        mode_r <= sel_mode_s;
                        cnt_r  <= '0;
                    end
                end
                ST_RD:   cnt_r <= cnt_r + CNT_ONE;
                ST_WB: begin
                    if (strobe_s && !last_s) cnt_r <= cnt_r + CNT_ONE;
                end
                ST_DONE: cnt_r <= '0;
                default: cnt_r <= cnt_r;
            endcase
        end
    end

    // Registered outputs toward the GLB and router
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            {iact_grant, wght_grant, psum_grant} <= 3'b000;
            {iact_done, wght_done, psum_done}    <= 3'b000;
            read_req_iact      <= 1'b0;
            read_req_wght      <= 1'b0;
            r_addr_iact        <= '0;
            r_addr_wght        <= '0;
            west_enable_i_iact <= 1'b0;
            west_enable_i_wght <= 1'b0;
            router_mode_iact   <= 4'd0;
            router_mode_wght   <= 4'd0;
            router_mode_psum   <= 4'd0;
            w_addr_psum        <= '0;
            busy               <= 1'b0;
        end else begin
            iact_grant         <= grant_s[0];
            wght_grant         <= grant_s[1];
            psum_grant         <= grant_s[2];
            iact_done          <= done_s[0];
            wght_done          <= done_s[1];
            psum_done          <= done_s[2];
            read_req_iact      <= rd_iact_s;
            read_req_wght      <= rd_wght_s;
            if (rd_iact_s) r_addr_iact <= addr_s;
            if (rd_wght_s) r_addr_wght <= addr_s;
            // one-cycle GLB read latency: data is valid to the router a cycle later
            west_enable_i_iact <= read_req_iact;
            west_enable_i_wght <= read_req_wght;
            if (grant_s[2])                w_addr_psum <= psum_base;
            else if (strobe_s && !last_s)  w_addr_psum <= w_addr_psum + ADDR_ONE;
            if (state_r != ST_IDLE) begin
                case (cls_r)
                    CLS_IACT: router_mode_iact <= mode_r;
                    CLS_WGHT: router_mode_wght <= mode_r;
                    CLS_PSUM: router_mode_psum <= mode_r;
                    default:  router_mode_psum <= router_mode_psum;
                endcase
            end
            busy <= (state_s != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_glb_router_sched.sv
// Directed self-checking bench for glb_router_sched.
module tb_glb_router_sched;

    localparam int AW = 10;
    localparam int LW = 10;

    logic          clk = 1'b0;
    logic          reset;
    logic          iact_req, wght_req, psum_req;
    logic [AW-1:0] iact_base, wght_base, psum_base;
    logic [LW-1:0] iact_len, wght_len, psum_len;
    logic [3:0]    iact_mode, wght_mode, psum_mode;
    logic          iact_grant, wght_grant, psum_grant;
    logic          iact_done, wght_done, psum_done;
    logic          read_req_iact, read_req_wght;
    logic [AW-1:0] r_addr_iact, r_addr_wght;
    logic          west_enable_i_iact, west_enable_i_wght;
    logic [3:0]    router_mode_iact, router_mode_wght, router_mode_psum;
    logic          west_enable_o_psum;
    logic [AW-1:0] w_addr_psum;
    logic          busy;

    int n_checks = 0;
    int n_fail   = 0;

    glb_router_sched #(.ADDR_BITWIDTH(AW), .LEN_W(LW)) dut (
        .clk(clk), .reset(reset),
        .iact_req(iact_req), .wght_req(wght_req), .psum_req(psum_req),
        .iact_base(iact_base), .wght_base(wght_base), .psum_base(psum_base),
        .iact_len(iact_len), .wght_len(wght_len), .psum_len(psum_len),
        .iact_mode(iact_mode), .wght_mode(wght_mode), .psum_mode(psum_mode),
        .iact_grant(iact_grant), .wght_grant(wght_grant), .psum_grant(psum_grant),
        .iact_done(iact_done), .wght_done(wght_done), .psum_done(psum_done),
        .read_req_iact(read_req_iact), .read_req_wght(read_req_wght),
        .r_addr_iact(r_addr_iact), .r_addr_wght(r_addr_wght),
        .west_enable_i_iact(west_enable_i_iact), .west_enable_i_wght(west_enable_i_wght),
        .router_mode_iact(router_mode_iact), .router_mode_wght(router_mode_wght),
        .router_mode_psum(router_mode_psum),
        .west_enable_o_psum(west_enable_o_psum), .w_addr_psum(w_addr_psum),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nr, nw, s, ov, dones;
        int grant_q[$];
        reset = 1'b0;
        {iact_req, wght_req, psum_req} = 3'b000;
        iact_base = '0; wght_base = '0; psum_base = '0;
        iact_len = '0; wght_len = '0; psum_len = '0;
        iact_mode = 4'd0; wght_mode = 4'd0; psum_mode = 4'd0;
        west_enable_o_psum = 1'b0;

        // reset values
        #12;
        chk("rst_strobes", 32'({iact_grant, wght_grant, psum_grant, iact_done, wght_done, psum_done,
                                read_req_iact, read_req_wght, west_enable_i_iact, west_enable_i_wght, busy}), 32'd0);
        chk("rst_addrs", 32'({r_addr_iact, r_addr_wght, w_addr_psum}), 32'd0);
        chk("rst_modes", 32'({router_mode_iact, router_mode_wght, router_mode_psum}), 32'd0);
        tick;
        reset = 1'b1;
        tick;

        // iact load base=0 len=4 mode=4
        iact_base = 10'd0; iact_len = 10'd4; iact_mode = 4'd4; iact_req = 1'b1;
        tick;
        chk("iact_grant", 32'(iact_grant), 32'd1);
        chk("iact_busy", 32'(busy), 32'd1);
        chk("iact_rd_T0", 32'(read_req_iact), 32'd0);
        iact_req = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            tick;
            chk($sformatf("iact_rd_T%0d", k), 32'(read_req_iact), 32'(k <= 4));
            if (k <= 4) chk($sformatf("iact_addr_T%0d", k), 32'(r_addr_iact), 32'(k - 1));
            chk($sformatf("iact_west_T%0d", k), 32'(west_enable_i_iact), 32'(k >= 2 && k <= 5));
            chk($sformatf("iact_done_T%0d", k), 32'(iact_done), 32'(k == 6));
            chk($sformatf("iact_mode_T%0d", k), 32'(router_mode_iact), 32'd4);
        end
        chk("iact_idle", 32'(busy), 32'd0);
        tick;

        // simultaneous requests: psum, then iact, then wght
        psum_base = 10'd20; psum_len = 10'd2; psum_mode = 4'd3;
        iact_base = 10'd5;  iact_len = 10'd1; iact_mode = 4'd1;
        wght_base = 10'd7;  wght_len = 10'd2; wght_mode = 4'd2;
        {iact_req, wght_req, psum_req} = 3'b111;
        west_enable_o_psum = 1'b1;
        ov = 0; dones = 0;
        for (int c = 0; c < 40; c++) begin
            tick;
            if (read_req_iact && read_req_wght) ov++;
            if (west_enable_i_iact && west_enable_i_wght) ov++;
            if (psum_grant) begin grant_q.push_back(2); psum_req = 1'b0; end
            if (iact_grant) begin grant_q.push_back(0); iact_req = 1'b0; end
            if (wght_grant) begin grant_q.push_back(1); wght_req = 1'b0; end
            dones += int'(iact_done) + int'(wght_done) + int'(psum_done);
        end
        chk("arb_ngrants", 32'(grant_q.size()), 32'd3);
        chk("arb_first",  32'((grant_q.size() > 0) ? grant_q[0] : -1), 32'd2);
        chk("arb_second", 32'((grant_q.size() > 1) ? grant_q[1] : -1), 32'd0);
        chk("arb_third",  32'((grant_q.size() > 2) ? grant_q[2] : -1), 32'd1);
        chk("arb_overlap", 32'(ov), 32'd0);
        chk("arb_dones", 32'(dones), 32'd3);
        chk("arb_modes", 32'({router_mode_psum, router_mode_iact, router_mode_wght}), 32'h312);
        chk("arb_waddr_hold", 32'(w_addr_psum), 32'd21);
        west_enable_o_psum = 1'b0;
        tick;

        // psum writeback base=8 len=8 mode=3, alternating strobes
        psum_base = 10'd8; psum_len = 10'd8; psum_mode = 4'd3; psum_req = 1'b1;
        tick;
        chk("psum_grant", 32'(psum_grant), 32'd1);
        chk("psum_waddr0", 32'(w_addr_psum), 32'd8);
        psum_req = 1'b0;
        s = 0;
        for (int i = 0; i < 16; i++) begin
            west_enable_o_psum = (i % 2 == 1);
            tick;
            if (i % 2 == 1) s++;
            chk($sformatf("psum_waddr_c%0d", i), 32'(w_addr_psum), 32'((s >= 8) ? 15 : 8 + s));
            chk($sformatf("psum_done_c%0d", i), 32'(psum_done), 32'(i == 15));
        end
        west_enable_o_psum = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick;
            chk($sformatf("psum_post_waddr%0d", i), 32'(w_addr_psum), 32'd15);
            chk($sformatf("psum_post_done%0d", i), 32'(psum_done), 32'd0);
        end
        chk("psum_idle", 32'(busy), 32'd0);
        chk("psum_mode", 32'(router_mode_psum), 32'd3);
        west_enable_o_psum = 1'b0;

        // wght load with address wrap
        wght_base = 10'd1022; wght_len = 10'd4; wght_mode = 4'd5; wght_req = 1'b1;
        tick;
        chk("wrap_grant", 32'(wght_grant), 32'd1);
        wght_req = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            tick;
            chk($sformatf("wrap_rd%0d", k), 32'(read_req_wght), 32'd1);
            chk($sformatf("wrap_addr%0d", k), 32'(r_addr_wght), 32'((1022 + k - 1) % 1024));
        end
        tick;
        tick;
        chk("wrap_done", 32'(wght_done), 32'd1);
        chk("wrap_mode", 32'(router_mode_wght), 32'd5);
        tick;

        // reset during RD at cnt=2
        iact_base = 10'd100; iact_len = 10'd6; iact_mode = 4'd7; iact_req = 1'b1;
        tick;
        iact_req = 1'b0;
        tick;
        tick;
        chk("mid_rd_active", 32'(read_req_iact), 32'd1);
        #1 reset = 1'b0;
        #1;
        chk("mid_rst_strobes", 32'({read_req_iact, read_req_wght, west_enable_i_iact, west_enable_i_wght,
                                    busy, iact_done, wght_done, psum_done}), 32'd0);
        chk("mid_rst_mode", 32'(router_mode_iact), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        tick;
        iact_base = 10'd200; iact_len = 10'd2; iact_mode = 4'd4; iact_req = 1'b1;
        tick;
        chk("restart_grant", 32'(iact_grant), 32'd1);
        iact_req = 1'b0;
        tick;
        chk("restart_addr0", 32'({read_req_iact, r_addr_iact}), 32'({1'b1, 10'd200}));
        tick;
        chk("restart_addr1", 32'({read_req_iact, r_addr_iact}), 32'({1'b1, 10'd201}));
        tick;
        chk("restart_drain", 32'({read_req_iact, west_enable_i_iact}), 32'b01);
        tick;
        chk("restart_done", 32'(iact_done), 32'd1);
        tick;

        // len=1 wght
        wght_base = 10'd50; wght_len = 10'd1; wght_mode = 4'd2; wght_req = 1'b1;
        tick;
        chk("len1_grant", 32'(wght_grant), 32'd1);
        wght_req = 1'b0;
        nr = 0; nw = 0;
        for (int k = 1; k <= 5; k++) begin
            tick;
            nr += int'(read_req_wght);
            nw += int'(west_enable_i_wght);
            if (k == 1) chk("len1_addr", 32'({read_req_wght, r_addr_wght}), 32'({1'b1, 10'd50}));
            chk($sformatf("len1_done_T%0d", k), 32'(wght_done), 32'(k == 3));
        end
        chk("len1_nread", 32'(nr), 32'd1);
        chk("len1_nwest", 32'(nw), 32'd1);

        // len=0 behaves as len=1
        iact_base = 10'd300; iact_len = 10'd0; iact_mode = 4'd6; iact_req = 1'b1;
        tick;
        iact_req = 1'b0;
        nr = 0;
        for (int k = 1; k <= 5; k++) begin
            tick;
            nr += int'(read_req_iact);
            chk($sformatf("len0_done_T%0d", k), 32'(iact_done), 32'(k == 3));
        end
        chk("len0_nread", 32'(nr), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/glb_router_sched.md
Name: glb_router_sched

Overview:
- Schedules transfers between the GLB cluster and the router cluster.
- Accepts up to three pending transfer descriptors: iact load, wght load and psum writeback. Arbitrates between them, then runs one at a time.
- Iact/wght transfers: drives GLB read request and address plus router west-enable and router mode.
- Psum writeback: sets router mode and generates GLB psum write addresses from router write strobes.

Parameters:
- ADDR_BITWIDTH, 10, GLB address width.
- LEN_W, 10, transfer length counter width. Length 0 is illegal and is treated as 1.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous active-low reset.
- iact_req / wght_req / psum_req  in  1 each  descriptor valid; held until matching grant.
- iact_base / wght_base / psum_base  in  ADDR_BITWIDTH each  first GLB address.
- iact_len / wght_len / psum_len  in  LEN_W each  number of words.
- iact_mode / wght_mode / psum_mode  in  4 each  router mode for the transfer.
- iact_grant / wght_grant / psum_grant  out  1 each  one-cycle pulse; descriptor captured.
- iact_done / wght_done / psum_done  out  1 each  one-cycle pulse at completion.
- read_req_iact / read_req_wght  out  1 each  GLB read strobe.
- r_addr_iact / r_addr_wght  out  ADDR_BITWIDTH each  GLB read address.
- west_enable_i_iact / west_enable_i_wght  out  1 each  router west-input valid.
- router_mode_iact / router_mode_wght / router_mode_psum  out  4 each  router configuration.
- west_enable_o_psum  in  1  router psum output strobe (also the GLB psum write enable).
- w_addr_psum  out  ADDR_BITWIDTH  GLB psum write address.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset values (asynchronous on reset=0): all outputs 0, FSM in IDLE, counters 0.
- FSM states: IDLE, RD, DRAIN, WB, DONE.
- Arbitration in IDLE is fixed priority: psum > iact > wght. It is non-preemptive.
- Grant cycle: capture base, len, mode and class into registers; pulse the class grant; go to RD (iact/wght) or WB (psum).
- Router mode output for the active class is driven from the captured mode from the cycle after grant until DONE.
- Mode outputs hold their last value while idle; other classes' modes are unchanged.
- RD state:
  - read_req_<c>=1 each cycle; r_addr_<c> = base + cnt; cnt increments each cycle.
  - After the read with cnt = len-1, go to DRAIN.
- GLB read latency is 1 cycle. west_enable_i_<c> is read_req_<c> delayed by one register. The first enable is one cycle after the first read_req; the last enable occurs in DRAIN.
- DRAIN: one cycle; read_req=0; west_enable_i=1 for the final word. Then go to DONE.
- WB state:
  - w_addr_psum = base + cnt combinationally from registered cnt.
  - Each cycle with west_enable_o_psum=1, cnt increments. When the strobe arrives with cnt = len-1, go to DONE.
  - Strobes outside WB are ignored; w_addr_psum holds.
- DONE: pulse <c>_done for one cycle; cnt cleared; return to IDLE. A new grant is possible in the following cycle, which makes IDLE at least one cycle between transfers.
- Address arithmetic is modulo 2^ADDR_BITWIDTH; base + cnt wraps past all-ones to 0.
- Simultaneous requests: highest priority wins; losers stay pending and are served in later IDLE visits.
- A request deasserted before its grant is dropped silently.
- Reset mid-transfer: all strobes drop immediately, no done pulse, pending descriptors are forgotten.
- Only one of read_req_iact / read_req_wght is ever high. The same holds for west_enable_i_iact / west_enable_i_wght.

Test Plan:
- Iact load, base=0, len=4, mode=EAST(4):
  - grant pulse at cycle T; read_req_iact high T+1..T+4 with r_addr 0,1,2,3.
  - west_enable_i_iact high T+2..T+5; iact_done at T+6; router_mode_iact=4.
- Simultaneous iact_req, wght_req and psum_req:
  - psum granted first, then iact, then wght.
  - No overlap of read_req_iact / read_req_wght.
- Psum writeback, base=8, len=8, mode=WEST(3), strobes on alternating cycles:
  - w_addr_psum steps 8..15, advancing only after each strobe.
  - psum_done one cycle after the 8th strobe; strobes after done do not move the address.
- Wght load, base=1022, len=4:
  - r_addr_wght sequence 1022, 1023, 0, 1.
- Reset asserted during RD at cnt=2:
  - read_req, west_enable, busy and done all 0 immediately.
  - After release, a new iact_req restarts from its base.
- len=1 wght:
  - exactly one read_req and one west_enable; done two cycles after the read.
